// File: rtl/ppu_sparse_drain.sv
// Post-processing drain: scans every accumulator entry, applies ReLU/shift/saturate
// and run-length encodes the result into (value, zero-run) pairs for the OARAM.
module ppu_sparse_drain #(
  parameter int BANK_COUNT  = 32,
  parameter int ENTRIES     = 128,
  parameter int ACC_WIDTH   = 24,
  parameter int INDEX_WIDTH = 4,
  parameter int RAM_WIDTH   = 10
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [1:0]                    i_bitwidth,
  input  logic [4:0]                    i_quant_shift,
  output logic [$clog2(BANK_COUNT)-1:0] o_buffer_bank_read,
  output logic [$clog2(ENTRIES)-1:0]    o_buffer_bank_entry,
  output logic                          o_buffer_read_enable,
  input  logic [ACC_WIDTH-1:0]          i_buffer_data_read,
  output logic [7:0]                    o_oaram_value,
  output logic [INDEX_WIDTH-1:0]        o_oaram_index,
  output logic [RAM_WIDTH-1:0]          o_oaram_address,
  output logic                          o_oaram_write_enable,
  input  logic                          i_oaram_ready,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [RAM_WIDTH:0]            o_write_count,
  output logic                          o_overflow
);

  localparam int BW = $clog2(BANK_COUNT);
  localparam int EW = $clog2(ENTRIES);
  localparam logic [BW-1:0]          LAST_BANK  = BW'(BANK_COUNT - 1);
  localparam logic [EW-1:0]          LAST_ENTRY = EW'(ENTRIES - 1);
  localparam logic [INDEX_WIDTH-1:0] RUN_MAX    = {INDEX_WIDTH{1'b1}};
  localparam logic [RAM_WIDTH:0]     CAP        = {1'b1, {RAM_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_busy;
  logic                   w_done;
  logic                   r_busy;
  logic                   r_done;

  logic [BW-1:0]          r_bank;
  logic [EW-1:0]          r_entry;
  logic [1:0]             r_bw;
  logic [4:0]             r_shift;

  logic                   r_dv;
  logic                   r_hold_valid;
  logic [ACC_WIDTH-1:0]   r_hold_data;

  logic [INDEX_WIDTH-1:0] r_zrun;
  logic                   r_wr_en;
  logic [7:0]             r_value;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [RAM_WIDTH:0]     r_wr_count;
  logic                   r_overflow;

  logic                   w_stall;
  logic                   w_wr_done;
  logic                   w_last_rd;
  logic                   w_rd_issue;
  logic                   w_start_ok;
  logic                   w_s1_valid;
  logic [ACC_WIDTH-1:0]   w_s1_data;
  logic [7:0]             w_q;
  logic                   w_emit;
  logic [RAM_WIDTH:0]     w_count_after;
  logic                   w_room;
  logic                   w_pipe_empty;

  // ReLU, arithmetic shift (operand is non-negative after ReLU), saturate to mode width
  function automatic logic [7:0] quantise(input logic [ACC_WIDTH-1:0] data,
                                          input logic [4:0]           shift,
                                          input logic [1:0]           bw);
    logic [ACC_WIDTH-1:0] v;
    logic [ACC_WIDTH-1:0] q;
    logic [7:0]           lim;
    if (data[ACC_WIDTH-1]) begin
      v = '0;
    end else begin
      v = data;
    end
    q = v >> shift;
    case (bw)
      2'b01:   lim = 8'd15;
      2'b10:   lim = 8'd3;
      default: lim = 8'd255;
    endcase
    if (q > ACC_WIDTH'(lim)) begin
      quantise = lim;
    end else begin
      quantise = q[7:0];
    end
  endfunction

  // A pending write that is not accepted freezes the whole pipeline
  assign w_stall       = r_wr_en & ~i_oaram_ready;
  assign w_wr_done     = r_wr_en & i_oaram_ready;
  assign w_last_rd     = (r_bank == LAST_BANK) && (r_entry == LAST_ENTRY);
  assign w_rd_issue    = (r_state == ST_SCAN) && !w_stall;
  assign w_start_ok    = i_start && (r_state == ST_IDLE);
  assign w_s1_valid    = (r_hold_valid | r_dv) & ~w_stall;
  assign w_s1_data     = r_hold_valid ? r_hold_data : i_buffer_data_read;
  assign w_q           = quantise(w_s1_data, r_shift, r_bw);
  assign w_emit        = w_s1_valid && ((w_q != 8'd0) || (r_zrun == RUN_MAX));
  assign w_count_after = r_wr_count + {{RAM_WIDTH{1'b0}}, w_wr_done};
  assign w_room        = (w_count_after < CAP);
  assign w_pipe_empty  = !r_dv && !r_hold_valid && !r_wr_en;

  // FSM state register plus registered busy/done
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_SCAN;
        else         w_next_state = ST_IDLE;
      end
      ST_SCAN: begin
        if (w_rd_issue && w_last_rd) w_next_state = ST_FLUSH;
        else                         w_next_state = ST_SCAN;
      end
      ST_FLUSH: begin
        if (w_pipe_empty) w_next_state = ST_DONE;
        else              w_next_state = ST_FLUSH;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the next state so the registered copies align with it
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (w_next_state)
      ST_SCAN:  w_busy = 1'b1;
      ST_FLUSH: w_busy = 1'b1;
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Bank-major read address walk and configuration latch
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bank  <= '0;
      r_entry <= '0;
      r_bw    <= 2'b00;
      r_shift <= 5'd0;
    end else if (w_start_ok) begin
      r_bank  <= '0;
      r_entry <= '0;
      r_bw    <= i_bitwidth;
      r_shift <= i_quant_shift;
    end else if (w_rd_issue) begin
      if (r_entry == LAST_ENTRY) begin
        r_entry <= '0;
        if (r_bank == LAST_BANK) r_bank <= '0;
        else                     r_bank <= r_bank + BW'(1'b1);
      end else begin
        r_entry <= r_entry + EW'(1'b1);
      end
    end
  end

  // Read-data valid tracking; data landing during a stall parks in the hold register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dv         <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else begin
      r_dv <= w_rd_issue;
      if (r_dv && w_stall) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= i_buffer_data_read;
      end else if (!w_stall) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  // Run-length encoder, OARAM write register and capacity tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_zrun     <= '0;
      r_wr_en    <= 1'b0;
      r_value    <= 8'd0;
      r_index    <= '0;
      r_wr_count <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_zrun     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_count <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_done) r_wr_count <= w_count_after;
      if (!w_stall) begin
        r_wr_en <= w_emit && w_room;
        if (w_emit && w_room) begin
          r_value <= w_q;
          r_index <= r_zrun;
        end
        if (w_emit && !w_room) r_overflow <= 1'b1;
      end
      // The run restarts after every emitted pair, even one dropped for lack of room
      if (w_s1_valid) begin
        if (w_emit) r_zrun <= '0;
        else        r_zrun <= r_zrun + INDEX_WIDTH'(1'b1);
      end
    end
  end

  assign o_buffer_bank_read   = r_bank;
  assign o_buffer_bank_entry  = r_entry;
  assign o_buffer_read_enable = w_rd_issue;
  assign o_oaram_value        = r_value;
  assign o_oaram_index        = r_index;
  assign o_oaram_address      = r_wr_count[RAM_WIDTH-1:0];
  assign o_oaram_write_enable = r_wr_en;
  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_write_count        = r_wr_count;
  assign o_overflow           = r_overflow;

endmodule

// File: tb/tb_ppu_sparse_drain.sv
// Directed scoreboard bench: two drain instances (small RAM and tiny RAM) with
// behavioural accumulator memories; expected OARAM writes are queued per test.
module tb_ppu_sparse_drain;

  logic clk;
  int   errors;
  int   checks;

  typedef struct packed {
    logic [7:0] v;
    logic [3:0] i;
    logic [9:0] a;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];

  // Instance A: 2x4 entries, 1024-entry OARAM
  logic        a_reset, a_start, a_rden, a_we, a_ready, a_busy, a_done, a_ovf;
  logic [1:0]  a_bw;
  logic [4:0]  a_shift;
  logic [0:0]  a_bank;
  logic [1:0]  a_entry;
  logic [23:0] a_data;
  logic [7:0]  a_val;
  logic [3:0]  a_idx;
  logic [9:0]  a_addr;
  logic [10:0] a_wc;
  logic [23:0] mem_a [0:7];

  // Instance B: 2x16 entries, 4-entry OARAM
  logic        b_reset, b_start, b_rden, b_we, b_ready, b_busy, b_done, b_ovf;
  logic [1:0]  b_bw;
  logic [4:0]  b_shift;
  logic [0:0]  b_bank;
  logic [3:0]  b_entry;
  logic [23:0] b_data;
  logic [7:0]  b_val;
  logic [3:0]  b_idx;
  logic [1:0]  b_addr;
  logic [2:0]  b_wc;
  logic [23:0] mem_b [0:31];

  ppu_sparse_drain #(.BANK_COUNT(2), .ENTRIES(4), .ACC_WIDTH(24), .INDEX_WIDTH(4), .RAM_WIDTH(10)) u_dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_start(a_start), .i_bitwidth(a_bw), .i_quant_shift(a_shift),
    .o_buffer_bank_read(a_bank), .o_buffer_bank_entry(a_entry), .o_buffer_read_enable(a_rden),
    .i_buffer_data_read(a_data), .o_oaram_value(a_val), .o_oaram_index(a_idx),
    .o_oaram_address(a_addr), .o_oaram_write_enable(a_we), .i_oaram_ready(a_ready),
    .o_busy(a_busy), .o_done(a_done), .o_write_count(a_wc), .o_overflow(a_ovf)
  );

  ppu_sparse_drain #(.BANK_COUNT(2), .ENTRIES(16), .ACC_WIDTH(24), .INDEX_WIDTH(4), .RAM_WIDTH(2)) u_dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_start(b_start), .i_bitwidth(b_bw), .i_quant_shift(b_shift),
    .o_buffer_bank_read(b_bank), .o_buffer_bank_entry(b_entry), .o_buffer_read_enable(b_rden),
    .i_buffer_data_read(b_data), .o_oaram_value(b_val), .o_oaram_index(b_idx),
    .o_oaram_address(b_addr), .o_oaram_write_enable(b_we), .i_oaram_ready(b_ready),
    .o_busy(b_busy), .o_done(b_done), .o_write_count(b_wc), .o_overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator memories: data returned one cycle after the read request
  always @(posedge clk) begin
    if (a_rden) a_data <= mem_a[{a_bank, a_entry}];
    if (b_rden) b_data <= mem_b[{b_bank, b_entry}];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_a(input logic [7:0] v, input logic [3:0] i, input logic [9:0] a);
    qa.push_back('{v: v, i: i, a: a});
  endtask

  task automatic exp_b(input logic [7:0] v, input logic [3:0] i, input logic [9:0] a);
    qb.push_back('{v: v, i: i, a: a});
  endtask

  // Write monitors: pop on each accepted write, and require stalled writes to hold
  logic        a_stalled, b_stalled;
  logic [22:0] a_saved, b_saved;
  initial begin
    a_stalled = 1'b0;
    b_stalled = 1'b0;
    a_saved = '0;
    b_saved = '0;
  end

  always @(negedge clk) begin
    wr_t e;
    if (a_stalled) check("a_hold_stable", {a_val, a_idx, a_addr, a_we}, a_saved);
    a_stalled = 1'b0;
    if (a_we === 1'b1) begin
      if (a_ready) begin
        check("a_write_expected", (qa.size() != 0), 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_value", a_val, e.v);
          check("a_index", a_idx, e.i);
          check("a_addr", a_addr, e.a);
        end
      end else begin
        a_stalled = 1'b1;
        a_saved = {a_val, a_idx, a_addr, a_we};
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (b_stalled) check("b_hold_stable", {b_val, b_idx, 8'd0, b_addr, b_we}, b_saved);
    b_stalled = 1'b0;
    if (b_we === 1'b1) begin
      if (b_ready) begin
        check("b_write_expected", (qb.size() != 0), 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_value", b_val, e.v);
          check("b_index", b_idx, e.i);
          check("b_addr", {8'd0, b_addr}, e.a);
        end
      end else begin
        b_stalled = 1'b1;
        b_saved = {b_val, b_idx, 8'd0, b_addr, b_we};
      end
    end
  end

  // Pulse start for one sampling edge; returns just after that edge
  task automatic start_dut(input bit sel_b, input logic [1:0] bw, input logic [4:0] sh);
    @(posedge clk); #1;
    if (sel_b) begin
      b_bw = bw; b_shift = sh; b_start = 1'b1;
    end else begin
      a_bw = bw; a_shift = sh; a_start = 1'b1;
    end
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Run until done pulses (bounded), optionally toggling A's ready 1,0,0,1
  task automatic run_dut(input bit sel_b, input bit toggle, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (toggle) a_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(negedge clk);
      seen = sel_b ? b_done : a_done;
      if (!seen) begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_done"}, seen, 1);
    @(posedge clk); #1;
    a_ready = 1'b1;
  endtask

  initial begin
    bit early;
    bit any_done;
    errors = 0;
    checks = 0;
    a_reset = 1'b1; a_start = 1'b0; a_bw = 2'b00; a_shift = 5'd0; a_ready = 1'b1;
    b_reset = 1'b1; b_start = 1'b0; b_bw = 2'b00; b_shift = 5'd0; b_ready = 1'b1;
    a_data = '0;
    b_data = '0;
    for (int i = 0; i < 8; i++) mem_a[i] = 24'd0;
    for (int i = 0; i < 32; i++) mem_b[i] = 24'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {a_busy, a_done, a_we, a_rden, a_ovf, a_wc, a_addr, a_val, a_idx}, 0);
    check("reset_b", {b_busy, b_done, b_we, b_rden, b_ovf, b_wc, b_addr, b_val, b_idx}, 0);
    @(posedge clk); #1;
    a_reset = 1'b0;
    b_reset = 1'b0;

    // All zeros: no writes, done exactly 10 edges after start is sampled
    start_dut(1'b0, 2'b00, 5'd0);
    early = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) check("t1_busy", a_busy, 1);
      if (k < 10) early = early | a_done;
    end
    check("t1_no_early_done", early, 0);
    check("t1_done_at_10", a_done, 1);
    check("t1_write_count", a_wc, 0);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(negedge clk);
    check("t1_start_in_done_ignored", {a_busy, a_done}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_still_idle", a_busy, 0);

    // Mixed data, 8-bit mode
    mem_a[0] = 24'd0;   mem_a[1] = 24'd0; mem_a[2] = 24'd5; mem_a[3] = 24'd0;
    mem_a[4] = -24'sd3; mem_a[5] = 24'd300; mem_a[6] = 24'd0; mem_a[7] = 24'd7;
    exp_a(8'd5, 4'd2, 10'd0); exp_a(8'd255, 4'd2, 10'd1); exp_a(8'd7, 4'd1, 10'd2);
    start_dut(1'b0, 2'b00, 5'd0);
    run_dut(1'b0, 1'b0, "t2");
    check("t2_sb_empty", qa.size(), 0);
    check("t2_write_count", a_wc, 3);
    check("t2_overflow", a_ovf, 0);

    // Same data, 4-bit mode, shift 1
    exp_a(8'd2, 4'd2, 10'd0); exp_a(8'd15, 4'd2, 10'd1); exp_a(8'd3, 4'd1, 10'd2);
    start_dut(1'b0, 2'b01, 5'd1);
    run_dut(1'b0, 1'b0, "t3");
    check("t3_sb_empty", qa.size(), 0);
    check("t3_write_count", a_wc, 3);

    // 2-bit mode, shift 2
    exp_a(8'd1, 4'd2, 10'd0); exp_a(8'd3, 4'd2, 10'd1); exp_a(8'd1, 4'd1, 10'd2);
    start_dut(1'b0, 2'b10, 5'd2);
    run_dut(1'b0, 1'b0, "t3b");
    check("t3b_sb_empty", qa.size(), 0);

    // Mode 11 behaves as 8-bit; shift 3 leaves only 300 -> 37, trailing zeros dropped
    exp_a(8'd37, 4'd5, 10'd0);
    start_dut(1'b0, 2'b11, 5'd3);
    run_dut(1'b0, 1'b0, "t3c");
    check("t3c_sb_empty", qa.size(), 0);
    check("t3c_write_count", a_wc, 1);

    // All ones: ready=1 run, then ready toggling 1,0,0,1 must give the same stream
    for (int i = 0; i < 8; i++) mem_a[i] = 24'd1;
    for (int i = 0; i < 8; i++) exp_a(8'd1, 4'd0, 10'(i));
    start_dut(1'b0, 2'b00, 5'd0);
    run_dut(1'b0, 1'b0, "t5_ready1");
    check("t5_ready1_sb_empty", qa.size(), 0);
    for (int i = 0; i < 8; i++) exp_a(8'd1, 4'd0, 10'(i));
    start_dut(1'b0, 2'b00, 5'd0);
    run_dut(1'b0, 1'b1, "t5_toggle");
    check("t5_toggle_sb_empty", qa.size(), 0);
    check("t5_toggle_write_count", a_wc, 8);

    // 20 zeros then 9: run-limit marker pair (0,15) then (9,4)
    mem_b[20] = 24'd9;
    exp_b(8'd0, 4'd15, 10'd0); exp_b(8'd9, 4'd4, 10'd1);
    start_dut(1'b1, 2'b00, 5'd0);
    run_dut(1'b1, 1'b0, "t4");
    check("t4_sb_empty", qb.size(), 0);
    check("t4_write_count", b_wc, 2);
    check("t4_overflow", b_ovf, 0);

    // Six nonzero entries into a 4-entry OARAM
    mem_b[20] = 24'd0;
    for (int i = 0; i < 6; i++) mem_b[i] = 24'(i + 1);
    for (int i = 0; i < 4; i++) exp_b(8'(i + 1), 4'd0, 10'(i));
    start_dut(1'b1, 2'b00, 5'd0);
    run_dut(1'b1, 1'b0, "t6");
    check("t6_sb_empty", qb.size(), 0);
    check("t6_overflow", b_ovf, 1);
    check("t6_write_count", b_wc, 4);

    // Reset in the middle of a scan aborts without done
    for (int i = 0; i < 32; i++) mem_b[i] = 24'd0;
    start_dut(1'b1, 2'b00, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_busy_before_reset", b_busy, 1);
    @(posedge clk); #1;
    b_reset = 1'b1;
    @(posedge clk); #1;
    b_reset = 1'b0;
    @(negedge clk);
    check("t6_reset_abort", {b_busy, b_done, b_rden, b_we, b_ovf, b_wc}, 0);
    any_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      any_done = any_done | b_done | b_busy;
    end
    check("t6_no_done_after_reset", any_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
